usr_param: RTL and testbench
============================

USR_PARAM -- requirements
Module: usr_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, register width in bits (min 2).
REQ-002 The block SHALL have parameter CNT_W, default 4, width of the burst shift-count input.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1, single-operation enable, sampled only in IDLE.
REQ-006 The block SHALL have port sel, input, 3, operation select.
REQ-007 The block SHALL have port in, input, WIDTH, parallel load data.
REQ-008 The block SHALL have port sin_r, input, 1, serial bit entering the MSB on a right shift.
REQ-009 The block SHALL have port sin_l, input, 1, serial bit entering the LSB on a left shift.
REQ-010 The block SHALL have port start, input, 1, burst request, sampled only in IDLE.
REQ-011 The block SHALL have port cnt, input, CNT_W, number of burst shifts.
REQ-012 The block SHALL have port y, output, WIDTH, register contents (registered).
REQ-013 The block SHALL have port busy, output, 1, high while a burst is running (registered).
REQ-014 The block SHALL have port done, output, 1, one-cycle pulse at burst end (registered).

Function
REQ-015 The block SHALL use these sel encodings: 000 hold; 001 shr {sin_r,y[W-1:1]}; 010 shl {y[W-2:0],sin_l}; 011 load in; 100 rotr {y[0],y[W-1:1]}; 101 rotl {y[W-2:0],y[W-1]}; 110 ashr {y[W-1],y[W-1:1]}; 111 hold.
REQ-016 In IDLE with en=1 and start=0, the block SHALL apply the sel operation to y at that edge (latency 1 cycle).
REQ-017 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-018 In IDLE, start=1 with cnt>0 and sel a shift/rotate code SHALL latch sel, sin_r, sin_l and cnt, leave y unchanged, set busy=1 and move to RUN; start takes priority over en.
REQ-019 In RUN, each edge SHALL apply the latched op once and decrement the remaining count; at remaining=0 after an op the FSM SHALL move to DONE and clear busy.
REQ-020 DONE SHALL last exactly one cycle with done=1 and then return to IDLE; start-to-done latency is cnt+1 cycles.
REQ-021 start with cnt=0, or with sel in {000,011,111}, SHALL go straight to DONE (one done pulse, busy stays 0, y unchanged).
REQ-022 While in RUN or DONE, en, start, sel, in and cnt SHALL be ignored.
REQ-023 A count wrapping past zero SHALL be impossible; the burst length SHALL be exactly cnt.

Reset
REQ-024 rst=0 SHALL asynchronously force y=0, busy=0, done=0, FSM=IDLE and clear all latched state, including mid-burst (the burst is aborted with no done pulse).
REQ-025 After rst deasserts, the first operation SHALL take effect at the next rising clk edge.

Configuration
REQ-026 With USR_ROTATE_EN defined, codes 100/101 SHALL rotate as in REQ-015; without it, 100/101 SHALL behave as hold and SHALL count as non-shift codes for REQ-021.

Structure
REQ-027 A shared package usr_pkg SHALL hold the sel encoding constants (OP_HOLD, OP_SHR, OP_SHL, OP_LOAD, OP_ROTR, OP_ROTL, OP_ASHR) and the FSM state type.
REQ-028 The IDLE/RUN/DONE FSM and down-counter SHALL live in the sub-module usr_burst_ctrl; the datapath mux SHALL live in usr_param.

Verification (WIDTH=4, USR_ROTATE_EN defined)
REQ-029 The bench SHALL cover: rst=0 mid-operation -> y=0000, busy=0, done=0 immediately, without waiting for a clock edge.
REQ-030 The bench SHALL cover: en=1, sel=011, in=1011 -> y=1011; then sel=001, sin_r=0 -> 0101; reload, then sel=010, sin_l=1 -> 0111.
REQ-031 The bench SHALL cover: from y=1011, sel=100 -> 1101; from 1011, sel=110 -> 1101; from 1011, sel=101 -> 0111.
REQ-032 The bench SHALL cover: y=1011, start=1, sel=010, cnt=3, sin_l=0 -> busy for 3 cycles, y sequence 0110, 1100, 1000, then done=1 for exactly one cycle, then IDLE.
REQ-033 The bench SHALL cover: start=1 with cnt=0 -> single done pulse, y unchanged, busy never high; start=1 during RUN -> ignored.
REQ-034 The bench SHALL cover: rst=0 in the middle of a 5-shift burst -> y=0000, busy=0, no done pulse; a new burst after release runs normally.

Source files
------------

// File: rtl/usr_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | usr_pkg : operation codes, FSM state type and burst-op classifier |
// | Optional feature macro: USR_ROTATE_EN.       Revision: 1.0        |
// +------------------------------------------------------------------+
package usr_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROTR = 3'b100;
  localparam logic [2:0] OP_ROTL = 3'b101;
  localparam logic [2:0] OP_ASHR = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True for codes that move bits; only these may start a real burst.
  function automatic logic is_burst_op(input logic [2:0] op);
    logic r;
    case (op)
      OP_SHR, OP_SHL, OP_ASHR: r = 1'b1;
`ifdef USR_ROTATE_EN
      OP_ROTR, OP_ROTL:        r = 1'b1;
`else
      OP_ROTR, OP_ROTL:        r = 1'b0;
`endif
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/usr_burst_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | usr_burst_ctrl : IDLE/RUN/DONE sequencer, latched op, down-count  |
// | Optional feature macro: USR_ROTATE_EN.       Revision: 1.0        |
// +------------------------------------------------------------------+
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       sel,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [CNT_W-1:0] cnt,
  output logic             apply,
  output logic [2:0]       op,
  output logic             op_sin_r,
  output logic             op_sin_l,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_remain;
  logic [2:0]       r_op;
  logic             r_sin_r;
  logic             r_sin_l;
  logic             r_busy;
  logic             r_done;

  always_comb begin
    w_state_nxt = r_state;
    apply       = 1'b0;
    op          = sel;
    op_sin_r    = sin_r;
    op_sin_l    = sin_l;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if ((cnt != '0) && is_burst_op(sel)) w_state_nxt = ST_RUN;
          else                                 w_state_nxt = ST_DONE;
        end else if (en) begin
          apply = 1'b1;
        end
      end
      ST_RUN: begin
        apply    = 1'b1;
        op       = r_op;
        op_sin_r = r_sin_r;
        op_sin_l = r_sin_l;
        // Leave on the op that consumes the last count so it never wraps.
        if (r_remain == CNT_W'(1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_remain <= '0;
      r_op     <= OP_HOLD;
      r_sin_r  <= 1'b0;
      r_sin_l  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
      if ((r_state == ST_IDLE) && start) begin
        r_op     <= sel;
        r_sin_r  <= sin_r;
        r_sin_l  <= sin_l;
        r_remain <= cnt;
      end else if (r_state == ST_RUN) begin
        r_remain <= r_remain - CNT_W'(1);
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: rtl/usr_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | usr_param : universal shift register with single ops and bursts   |
// | Optional feature macro: USR_ROTATE_EN.       Revision: 1.0        |
// +------------------------------------------------------------------+
module usr_param
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] in,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] w_y_nxt;
  logic             w_apply;
  logic [2:0]       w_op;
  logic             w_sin_r;
  logic             w_sin_l;

  usr_burst_ctrl #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .sel      (sel),
    .sin_r    (sin_r),
    .sin_l    (sin_l),
    .cnt      (cnt),
    .apply    (w_apply),
    .op       (w_op),
    .op_sin_r (w_sin_r),
    .op_sin_l (w_sin_l),
    .busy     (busy),
    .done     (done)
  );

  always_comb begin
    w_y_nxt = r_y;
    case (w_op)
      OP_HOLD: w_y_nxt = r_y;
      OP_SHR:  w_y_nxt = {w_sin_r, r_y[WIDTH-1:1]};
      OP_SHL:  w_y_nxt = {r_y[WIDTH-2:0], w_sin_l};
      OP_LOAD: w_y_nxt = in;
`ifdef USR_ROTATE_EN
      OP_ROTR: w_y_nxt = {r_y[0], r_y[WIDTH-1:1]};
      OP_ROTL: w_y_nxt = {r_y[WIDTH-2:0], r_y[WIDTH-1]};
`endif
      OP_ASHR: w_y_nxt = {r_y[WIDTH-1], r_y[WIDTH-1:1]};
      default: w_y_nxt = r_y;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_y <= '0;
    else if (w_apply) r_y <= w_y_nxt;
  end

  assign y = r_y;

endmodule
`default_nettype wire

// File: tb/tb_usr_param.sv
`default_nettype none
// Self-checking bench for usr_param (WIDTH=4): directed vector table,
// hand-written burst/reset sequences and a randomized queue-based model.
module tb_usr_param;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
`ifdef USR_ROTATE_EN
  localparam bit c_rot = 1'b1;
`else
  localparam bit c_rot = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             start = 1'b0;
  logic             sin_r = 1'b0;
  logic             sin_l = 1'b0;
  logic [2:0]       sel = 3'b000;
  logic [WIDTH-1:0] din = '0;
  logic [CNT_W-1:0] cnt = '0;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;

  usr_param #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .in(din),
    .sin_r(sin_r), .sin_l(sin_l), .start(start), .cnt(cnt),
    .y(y), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an idle register plus a queue of pending burst work.
  // Token 1 = one latched op still to apply, token 0 = the done cycle.
  logic [3:0] m_y = '0;
  bit         m_q[$];
  logic [2:0] m_op;
  logic       m_sr, m_sl;

  function automatic bit is_shift(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2) || (op == 3'd6) ||
           (c_rot && ((op == 3'd4) || (op == 3'd5)));
  endfunction

  function automatic logic [3:0] f_apply(input logic [2:0] op, input logic [3:0] v,
                                         input logic [3:0] d, input logic sr, input logic sl);
    int u;
    u = int'(v);
    case (op)
      3'd1: u = (u / 2) + (sr ? 8 : 0);
      3'd2: u = ((u * 2) % 16) + (sl ? 1 : 0);
      3'd3: u = int'(d);
      3'd4: if (c_rot) u = (u / 2) + ((u % 2) * 8);
      3'd5: if (c_rot) u = ((u * 2) % 16) + (u / 8);
      3'd6: u = (u / 2) + ((u >= 8) ? 8 : 0);
      default: u = int'(v);
    endcase
    return 4'(u);
  endfunction

  task automatic model_edge();
    bit t;
    if (m_q.size() == 0) begin
      if (start) begin
        if ((cnt != 0) && is_shift(sel)) begin
          m_op = sel; m_sr = sin_r; m_sl = sin_l;
          for (int i = 0; i < int'(cnt); i++) m_q.push_back(1'b1);
        end
        m_q.push_back(1'b0);
      end else if (en) begin
        m_y = f_apply(sel, m_y, din, sin_r, sin_l);
      end
    end else begin
      t = m_q.pop_front();
      if (t) m_y = f_apply(m_op, m_y, din, m_sr, m_sl);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    bit eb, ed;
    eb = (m_q.size() > 0) && m_q[0];
    ed = (m_q.size() > 0) && !m_q[0];
    chk({tag, "_y"}, 32'(y), 32'(m_y));
    chk({tag, "_busy"}, 32'(busy), 32'(eb));
    chk({tag, "_done"}, 32'(done), 32'(ed));
  endtask

  task automatic idle_inputs();
    en = 1'b0; start = 1'b0; sel = 3'b000; cnt = '0; sin_r = 1'b0; sin_l = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_rst_y"}, 32'(y), 32'h0);
    chk({tag, "_rst_busy"}, 32'(busy), 32'h0);
    chk({tag, "_rst_done"}, 32'(done), 32'h0);
    m_y = '0;
    m_q.delete();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load(input logic [3:0] v);
    idle_inputs();
    en = 1'b1; sel = 3'b011; din = v;
    tick();
  endtask

  typedef struct {
    logic [3:0] pre;
    logic [2:0] op;
    logic       sr;
    logic       sl;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic [3:0] pre, input logic [2:0] op,
                              input logic sr, input logic sl, input logic [3:0] exp);
    vec_t v;
    v.pre = pre; v.op = op; v.sr = sr; v.sl = sl; v.exp = exp;
    return v;
  endfunction

  initial begin
    vecs[0]  = mk(4'b1011, 3'b001, 1'b0, 1'b0, 4'b0101);
    vecs[1]  = mk(4'b1011, 3'b010, 1'b0, 1'b1, 4'b0111);
    vecs[2]  = mk(4'b1011, 3'b100, 1'b0, 1'b0, c_rot ? 4'b1101 : 4'b1011);
    vecs[3]  = mk(4'b1011, 3'b110, 1'b0, 1'b0, 4'b1101);
    vecs[4]  = mk(4'b1011, 3'b101, 1'b0, 1'b0, c_rot ? 4'b0111 : 4'b1011);
    vecs[5]  = mk(4'b1011, 3'b000, 1'b1, 1'b1, 4'b1011);
    vecs[6]  = mk(4'b1011, 3'b111, 1'b1, 1'b1, 4'b1011);
    vecs[7]  = mk(4'b0110, 3'b001, 1'b1, 1'b0, 4'b1011);
    vecs[8]  = mk(4'b0110, 3'b110, 1'b0, 1'b0, 4'b0011);
    vecs[9]  = mk(4'b1000, 3'b010, 1'b0, 1'b0, 4'b0000);
    vecs[10] = mk(4'b0001, 3'b100, 1'b0, 1'b0, c_rot ? 4'b1000 : 4'b0001);
    vecs[11] = mk(4'b1000, 3'b101, 1'b0, 1'b0, c_rot ? 4'b0001 : 4'b1000);

    // Reset state, then release away from a clock edge.
    #2;
    chk("reset_y", 32'(y), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    load(4'b1011);
    chk("load_1011", 32'(y), 32'hB);

    for (int i = 0; i < 12; i++) begin
      load(vecs[i].pre);
      idle_inputs();
      en = 1'b1; sel = vecs[i].op; sin_r = vecs[i].sr; sin_l = vecs[i].sl;
      din = ~vecs[i].pre;
      tick();
      chk($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
    end

    // en=0 holds the register regardless of sel.
    load(4'b1011);
    idle_inputs();
    sel = 3'b011; din = 4'b0000;
    tick();
    chk("en0_hold", 32'(y), 32'hB);

    // Burst: shl x3 from 1011 with sin_l=0.
    load(4'b1011);
    idle_inputs();
    start = 1'b1; sel = 3'b010; cnt = 4'd3; sin_l = 1'b0;
    tick();
    idle_inputs();
    chk("b3_start_y", 32'(y), 32'hB);
    chk("b3_start_busy", 32'(busy), 32'h1);
    tick();
    chk("b3_s1_y", 32'(y), 32'h6);
    chk("b3_s1_busy", 32'(busy), 32'h1);
    tick();
    chk("b3_s2_y", 32'(y), 32'hC);
    chk("b3_s2_busy", 32'(busy), 32'h1);
    chk("b3_s2_done", 32'(done), 32'h0);
    tick();
    chk("b3_s3_y", 32'(y), 32'h8);
    chk("b3_s3_busy", 32'(busy), 32'h0);
    chk("b3_s3_done", 32'(done), 32'h1);
    tick();
    chk("b3_after_done", 32'(done), 32'h0);
    chk("b3_after_y", 32'(y), 32'h8);
    load(4'b0101);
    chk("b3_idle_again", 32'(y), 32'h5);

    // cnt=0 and non-shift code: straight to a single done pulse.
    idle_inputs();
    start = 1'b1; sel = 3'b001; cnt = 4'd0;
    tick();
    idle_inputs();
    chk("cnt0_done", 32'(done), 32'h1);
    chk("cnt0_busy", 32'(busy), 32'h0);
    chk("cnt0_y", 32'(y), 32'h5);
    tick();
    chk("cnt0_done_off", 32'(done), 32'h0);
    start = 1'b1; sel = 3'b011; cnt = 4'd5; din = 4'b1111;
    tick();
    idle_inputs();
    chk("loadburst_done", 32'(done), 32'h1);
    chk("loadburst_busy", 32'(busy), 32'h0);
    chk("loadburst_y", 32'(y), 32'h5);
    tick();

    // start/en during RUN are ignored: shr x2 from 1100, sin_r=1.
    load(4'b1100);
    idle_inputs();
    start = 1'b1; sel = 3'b001; cnt = 4'd2; sin_r = 1'b1;
    tick();
    start = 1'b1; en = 1'b1; sel = 3'b011; cnt = 4'd9; din = 4'b0000; sin_r = 1'b0;
    tick();
    chk("run_ign_s1_y", 32'(y), 32'hE);
    tick();
    chk("run_ign_s2_y", 32'(y), 32'hF);
    chk("run_ign_s2_done", 32'(done), 32'h1);
    idle_inputs();
    tick();
    chk("run_ign_end_done", 32'(done), 32'h0);
    chk("run_ign_end_busy", 32'(busy), 32'h0);

    // Asynchronous reset mid-operation, no clock edge required.
    load(4'b1011);
    en = 1'b1; sel = 3'b001;
    async_reset("midop");

    // Reset mid 5-shift burst, then a fresh burst runs normally.
    load(4'b1111);
    idle_inputs();
    start = 1'b1; sel = 3'b010; cnt = 4'd5;
    tick();
    idle_inputs();
    tick();
    tick();
    async_reset("midburst");
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (done) pulses++;
      end
      chk("midburst_no_done", 32'(pulses), 32'h0);
      chk("midburst_y", 32'(y), 32'h0);
    end
    idle_inputs();
    start = 1'b1; sel = 3'b001; cnt = 4'd2; sin_r = 1'b1;
    tick();
    idle_inputs();
    tick();
    chk("post_rst_s1", 32'(y), 32'h8);
    tick();
    chk("post_rst_s2", 32'(y), 32'hC);
    chk("post_rst_done", 32'(done), 32'h1);
    tick();

    // Randomized traffic against the queue model.
    m_y = y;
    m_q.delete();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        async_reset("rnd");
      end else begin
        en    = ($urandom_range(0, 1) == 1);
        start = ($urandom_range(0, 99) < 15);
        sel   = 3'($urandom_range(0, 7));
        din   = 4'($urandom);
        sin_r = 1'($urandom);
        sin_l = 1'($urandom);
        cnt   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
        tick();
        check_model($sformatf("rnd%0d", n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
